// File: rtl/hazard_scoreboard.sv
// Register-busy scoreboard for an in-order pipeline: detects RAW/WAW and capacity
// hazards at decode. Optional stall counter enabled by HAZARD_SCOREBOARD_STALL_CNT_EN.
module hazard_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned MAX_OUT = 4,
    localparam int unsigned RW     = $clog2(NREG),
    localparam int unsigned CW     = $clog2(MAX_OUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic               issue_long,
    input  logic               issue_we,
    input  logic [RW-1:0]      issue_rd,
    input  logic [NSRC*RW-1:0] rs_dec,
    input  logic [NSRC-1:0]    rs_used,
    input  logic               wb_valid,
    input  logic [RW-1:0]      wb_rd,
    input  logic               kill_valid,
    input  logic [RW-1:0]      kill_rd,
    input  logic               flush_dec,
    output logic               stall_dec,
    output logic [NREG-1:0]    busy,
    output logic [CW-1:0]      outstanding,
    output logic               full,
    output logic [31:0]        stall_cycles
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] set_mask, clr_mask;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic            full_q, full_d;
    logic [NSRC-1:0] src_hz;
    logic [RW-1:0]   src_rd;
    logic            long_wr, waw_hz, cap_hz, accept, set_en;
    logic            add_one, wb_rm, kill_rm;

    // RAW check per source; a writeback landing this cycle releases the source
    always_comb begin
        src_hz = '0;
        src_rd = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src_rd    = rs_dec[i*RW +: RW];
            src_hz[i] = rs_used[i] && (src_rd != '0) && busy_q[src_rd]
                        && !(wb_valid && (wb_rd == src_rd));
        end
    end

    assign long_wr   = issue_we && issue_long && (issue_rd != '0);
    assign waw_hz    = long_wr && busy_q[issue_rd] && !(wb_valid && (wb_rd == issue_rd));
    assign cap_hz    = long_wr && full_q;
    assign stall_dec = issue_valid && !flush_dec && ((|src_hz) || waw_hz || cap_hz);
    assign accept    = issue_valid && !stall_dec && !flush_dec;
    assign set_en    = accept && long_wr;

    // Busy vector update: clears first, then set wins on the same register
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (wb_valid) begin
            clr_mask[wb_rd] = 1'b1;
        end
        if (kill_valid) begin
            clr_mask[kill_rd] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Count tracks popcount(busy): each distinct bit that actually flips counts once
    always_comb begin
        add_one       = set_en && !busy_q[issue_rd];
        wb_rm         = wb_valid && busy_q[wb_rd] && !(set_en && (issue_rd == wb_rd));
        kill_rm       = kill_valid && busy_q[kill_rd]
                        && !(set_en && (issue_rd == kill_rd))
                        && !(wb_valid && (wb_rd == kill_rd));
        outstanding_d = outstanding_q + CW'(add_one) - CW'(wb_rm) - CW'(kill_rm);
        full_d        = (outstanding_d == CW'(MAX_OUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            full_q        <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            full_q        <= full_d;
        end
    end

    assign busy        = busy_q;
    assign outstanding = outstanding_q;
    assign full        = full_q;

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of decode stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_dec && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, architectural register count; RW = $clog2(NREG).
REQ-002 SHALL have parameter NSRC, default 2, source operands checked per decode instruction.
REQ-003 SHALL have parameter MAX_OUT, default 4, max outstanding long-latency writes; CW = $clog2(MAX_OUT+1).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port issue_valid  in  1  decode instruction present.
REQ-007 SHALL have port issue_long  in  1  instruction is long-latency (load, divide), result not forwardable from EX.
REQ-008 SHALL have port issue_we  in  1  instruction writes rd.
REQ-009 SHALL have port issue_rd  in  RW  destination register.
REQ-010 SHALL have port rs_dec  in  NSRC*RW  packed sources, source i at [i*RW +: RW].
REQ-011 SHALL have port rs_used  in  NSRC  source i actually read.
REQ-012 SHALL have port wb_valid, wb_rd  in  1, RW  long-latency result written back.
REQ-013 SHALL have port kill_valid, kill_rd  in  1, RW  in-flight long op squashed by pc_change/flush.
REQ-014 SHALL have port flush_dec  in  1  decode instruction squashed this cycle.
REQ-015 SHALL have port stall_dec  out  1  hold IF/DEC, bubble into EX.
REQ-016 SHALL have port busy  out  NREG  pending-write bit per register.
REQ-017 SHALL have port outstanding  out  CW  count of set busy bits.
REQ-018 SHALL have port full  out  1  outstanding == MAX_OUT.
REQ-019 SHALL have port stall_cycles  out  32  stall event counter (see Configuration).

Function
REQ-020 SHALL compute per-source hazard: rs_used[i] & rs_i != 0 & busy[rs_i] & ~(wb_valid & wb_rd == rs_i) (same-cycle writeback releases combinationally).
REQ-021 SHALL compute WAW hazard: issue_we & issue_long & issue_rd != 0 & busy[issue_rd] & ~(wb_valid & wb_rd == issue_rd).
REQ-022 SHALL drive stall_dec = issue_valid & ~flush_dec & (any source hazard | WAW | (issue_long & issue_we & issue_rd != 0 & full)), purely combinational, zero-cycle latency.
REQ-023 SHALL accept issue when issue_valid & ~stall_dec & ~flush_dec; accepted long write with rd != 0 sets busy[issue_rd] next cycle.
REQ-024 SHALL clear busy[wb_rd] next cycle on wb_valid; clear busy[kill_rd] next cycle on kill_valid; either to a non-busy register is a no-op.
REQ-025 SHALL give set priority over clear when accepted issue and wb/kill target the same register in one cycle.
REQ-026 SHALL keep busy[0] permanently 0.
REQ-027 SHALL update outstanding by +1 per set and -1 per distinct busy bit cleared, same cycle, exactly matching popcount(busy); wb and kill to the same rd decrement once.
REQ-028 SHALL never let outstanding exceed MAX_OUT or underflow 0.
REQ-029 SHALL produce no X on outputs when rs_used bits are 0 regardless of rs_dec.

Reset
REQ-030 SHALL on rst=1 at a clock edge set busy=0, outstanding=0, stall_cycles=0; full=0 and stall_dec depends only on inputs thereafter.
REQ-031 SHALL give rst priority over simultaneous issue, wb and kill.

Configuration
REQ-032 SHALL with macro HAZARD_SCOREBOARD_STALL_CNT_EN defined increment stall_cycles by 1 each cycle stall_dec=1, saturating at 32'hFFFF_FFFF.
REQ-033 SHALL without HAZARD_SCOREBOARD_STALL_CNT_EN tie stall_cycles to 0 and instantiate no counter flops.

Verification
REQ-034 SHALL test load-use: issue long rd=5, next cycle rs_dec source0=5 used -> stall_dec=1 until wb_valid wb_rd=5, stall_dec=0 in that wb cycle.
REQ-035 SHALL test x0: issue long rd=0, then read x0 -> busy=0, outstanding=0, no stall.
REQ-036 SHALL test full: MAX_OUT=4, issue long to x1..x4 -> full=1, long issue to x6 stalls, ALU issue reading x7 not stalled.
REQ-037 SHALL test simultaneous: busy[3]=1, wb_rd=3 with accepted long issue rd=3 -> busy[3]=1, outstanding unchanged.
REQ-038 SHALL test kill: busy x8,x9, kill_rd=9 and wb_rd=8 same cycle -> busy=0, outstanding=0; rst mid-stall -> all cleared, stall_cycles=0.
